// File: rtl/execute_stage_if.sv
//------------------------------------------------------------------------------
// execute_stage_if : decoded-instruction in, register-file write port out
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface execute_stage_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        alu_op;
   logic [ADDR_W-1:0] rs_1;
   logic [ADDR_W-1:0] rs_2;
   logic [DATA_W-1:0] rout_1;
   logic [DATA_W-1:0] rout_2;
   logic [DATA_W-1:0] imm;
   logic              use_imm;
   logic [ADDR_W-1:0] rd;
   logic              out_valid;
   logic              out_ready;
   logic              write_enable;
   logic [ADDR_W-1:0] write_address;
   logic [DATA_W-1:0] write_data;

   modport master (
      output in_valid, alu_op, rs_1, rs_2, rout_1, rout_2, imm, use_imm, rd, out_ready,
      input  in_ready, out_valid, write_enable, write_address, write_data
   );

   modport slave (
      input  in_valid, alu_op, rs_1, rs_2, rout_1, rout_2, imm, use_imm, rd, out_ready,
      output in_ready, out_valid, write_enable, write_address, write_data
   );
endinterface

`default_nettype wire

// File: rtl/execute_stage.sv
//------------------------------------------------------------------------------
// execute_stage : ALU with self-forwarding, multi-cycle MUL, EX/WB result reg
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module execute_stage #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int MUL_LAT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   execute_stage_if.slave   bus
);

   localparam logic [3:0] c_OP_ADD  = 4'd0;
   localparam logic [3:0] c_OP_SUB  = 4'd1;
   localparam logic [3:0] c_OP_AND  = 4'd2;
   localparam logic [3:0] c_OP_OR   = 4'd3;
   localparam logic [3:0] c_OP_XOR  = 4'd4;
   localparam logic [3:0] c_OP_SLL  = 4'd5;
   localparam logic [3:0] c_OP_SRL  = 4'd6;
   localparam logic [3:0] c_OP_SRA  = 4'd7;
   localparam logic [3:0] c_OP_SLT  = 4'd8;
   localparam logic [3:0] c_OP_SLTU = 4'd9;
   localparam logic [3:0] c_OP_MUL  = 4'd10;
   localparam logic [3:0] c_MUL_CNT = 4'(MUL_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MUL_BUSY = 2'd1,
      S_RESULT   = 2'd2
   } state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0] r_result;

   logic              w_accept;
   logic              w_commit;
   logic              w_is_mul;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic [4:0]        w_shamt;
   logic [DATA_W-1:0] w_alu;

   assign bus.out_valid     = (r_state == S_RESULT);
   assign bus.in_ready      = (r_state == S_IDLE) | ((r_state == S_RESULT) & bus.out_ready);
   assign w_accept          = bus.in_valid & bus.in_ready;
   assign w_commit          = bus.out_valid & bus.out_ready;
   assign bus.write_enable  = w_commit;
   assign bus.write_address = r_rd;
   assign bus.write_data    = r_result;
   assign w_is_mul          = (bus.alu_op == c_OP_MUL);

   // The held result wins even if it commits this edge: the regfile read is stale.
   assign w_a     = (bus.out_valid && (r_rd == bus.rs_1)) ? r_result : bus.rout_1;
   assign w_b     = bus.use_imm ? bus.imm :
                    ((bus.out_valid && (r_rd == bus.rs_2)) ? r_result : bus.rout_2);
   assign w_shamt = w_b[4:0];

   always_comb begin
      w_alu = '0;
      case (bus.alu_op)
         c_OP_ADD:  w_alu = w_a + w_b;
         c_OP_SUB:  w_alu = w_a - w_b;
         c_OP_AND:  w_alu = w_a & w_b;
         c_OP_OR:   w_alu = w_a | w_b;
         c_OP_XOR:  w_alu = w_a ^ w_b;
         c_OP_SLL:  w_alu = w_a << w_shamt;
         c_OP_SRL:  w_alu = w_a >> w_shamt;
         c_OP_SRA:  w_alu = $signed(w_a) >>> w_shamt;
         c_OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
         c_OP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
         c_OP_MUL:  w_alu = w_a * w_b;
         default:   w_alu = '0;
      endcase
   end

   // The product is formed at accept; MUL_BUSY only paces its release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rd     <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_rd     <= bus.rd;
            r_result <= w_alu;
            r_cnt    <= c_MUL_CNT;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept)
                  r_state <= w_is_mul ? S_MUL_BUSY : S_RESULT;
            end
            S_MUL_BUSY: begin
               if (r_cnt == 4'd0)
                  r_state <= S_RESULT;
               else
                  r_cnt <= r_cnt - 4'd1;
            end
            S_RESULT: begin
               if (w_commit) begin
                  if (w_accept)
                     r_state <= w_is_mul ? S_MUL_BUSY : S_RESULT;
                  else
                     r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
